step_move_sequencer: RTL
========================

Name: step_move_sequencer

Overview:
- Move-level controller for the stepper phase-sequencer FSM: accepts a move command (step count, direction, full/half mode, step period) over a valid/ready handshake.
- Drives the sequencer's nStep, MotDir, OnOff, Hold and FullnHalf inputs to execute exactly that many steps at the programmed rate, then reports completion.
- Sits between the host command register file and the phase sequencer; the sequencer advances on the falling edge of nStep.

Parameters:
CNT_W, 16, width of step count and StepsLeft
DIV_W, 16, width of step period in Clk cycles
PULSE_LOW, 4, Clk cycles nStep is held low per step
RAMP_START, 16'd2000, initial step period when ramp enabled
RAMP_DEC, 16'd50, period decrement per step when ramp enabled

Ports:
Clk  in  1  system clock, all logic on rising edge
nReset  in  1  reset; asynchronous, active-low
Enable  in  1  motor power request
CmdValid  in  1  command present
CmdReady  out  1  command accepted when CmdValid & CmdReady
CmdSteps  in  CNT_W  steps to execute
CmdDir  in  1  1 = clockwise
CmdHalf  in  1  1 = half step
CmdPeriod  in  DIV_W  Clk cycles per step
Abort  in  1  stop current move
nStep  out  1  step clock to sequencer
MotDir  out  1  direction to sequencer
OnOff  out  1  phase power to sequencer
Hold  out  1  torque hold to sequencer
FullnHalf  out  1  1 = full step
Busy  out  1  move in progress
Done  out  1  one-cycle completion pulse
Aborted  out  1  Done was caused by Abort/Enable loss; valid with Done
StepsLeft  out  CNT_W  remaining steps

Behaviour:
- Reset values: nStep=1, MotDir=1, OnOff=0, Hold=1, FullnHalf=1, Busy=0, Done=0, Aborted=0, StepsLeft=0, CmdReady=0. FSM in IDLE.
- OnOff = registered Enable.
- CmdReady = (state==IDLE) & Enable.
- Effective period P = max(CmdPeriod, 2*PULSE_LOW), latched at accept.
- States:
  - IDLE: Hold=1, nStep=1. On handshake, latch CmdSteps into StepsLeft, MotDir=CmdDir, FullnHalf=~CmdHalf. If CmdSteps==0 -> DONE, else -> SETUP.
  - SETUP: one cycle; Busy=1, Hold=0, MotDir/FullnHalf stable (setup time for sequencer) -> LOW.
  - LOW: nStep=0 for PULSE_LOW cycles. StepsLeft decrements on entry (falling edge = one step) -> HIGH.
  - HIGH: nStep=1 for P-PULSE_LOW cycles. Then if StepsLeft==0 or abort pending -> DONE, else -> LOW.
  - DONE: Done=1 for one cycle, Busy=0, Hold=1 -> IDLE.
- Latency: accept at cycle t -> SETUP at t+1 -> first nStep fall at t+2. N steps -> Done at t+2+N*P.
- MotDir and FullnHalf never change while Busy.
- Abort in SETUP: -> DONE, no pulses. Abort in LOW: low phase completes, step counted, then DONE. Abort in HIGH: -> DONE next cycle. Aborted=1 with Done.
- Enable deasserted while Busy: treated as Abort. OnOff drops immediately.
- CmdValid while Busy: ignored, CmdReady=0.
- Counter wraps are impossible: StepsLeft is only decremented when nonzero.
- nReset assertion mid-move: all outputs return to reset values asynchronously, nStep=1 (no spurious falling edge).

Optional Feature:
STEP_RAMP_EN.
- Defined: trapezoidal profile. First step period = max(RAMP_START, P). Each subsequent step's period decreases by RAMP_DEC, floored at P. Steps spent accelerating are counted (RampCnt). Once StepsLeft <= RampCnt, period increases by RAMP_DEC per step (decel), mirroring acceleration.
- Undefined: constant period P; no ramp registers.

Decomposition:
- Shared package step_pkg: state encoding constants (IDLE, SETUP, LOW, HIGH, DONE), default PULSE_LOW, RAMP_START, RAMP_DEC.
- One sub-module: step_period_gen (loadable down-counter producing phase-end tick; contains ramp arithmetic under STEP_RAMP_EN).

Test Plan:
- Reset: nReset=0 mid-move -> all outputs at reset values same cycle; nStep stays 1.
- Full move: Enable=1, CmdSteps=3, CmdDir=1, CmdHalf=0, CmdPeriod=10 -> 3 nStep falls 10 cycles apart, first at accept+2, MotDir=1, FullnHalf=1, Done at accept+32, Aborted=0.
- Zero/clamp: CmdSteps=0 -> Done at accept+1, no pulses. CmdPeriod=3 -> periods of 8.
- Abort: CmdSteps=100, Abort during 5th HIGH -> Done next cycle, Aborted=1, StepsLeft=95, Hold=1.
- Enable loss: Enable=0 at step 2 -> OnOff=0 next cycle, Done+Aborted, CmdReady stays 0 until Enable=1.
- STEP_RAMP_EN: CmdSteps=10, CmdPeriod=1900, RAMP_START=2000, RAMP_DEC=50 -> periods 2000,1950,1900x6,1950,2000.

Source files
------------

// File: rtl/step_pkg.sv
// -----------------------------------------------------------------------------
// step_pkg
// Shared definitions for the stepper move controller:
//   state_e         - move FSM states (IDLE, SETUP, LOW, HIGH, DONE)
//   PULSE_LOW_DEF   - default nStep low time in Clk cycles
//   RAMP_START_DEF  - default first-step period when STEP_RAMP_EN is defined
//   RAMP_DEC_DEF    - default per-step period change when STEP_RAMP_EN is defined
// -----------------------------------------------------------------------------
package step_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  localparam int unsigned PULSE_LOW_DEF  = 4;
  localparam logic [15:0] RAMP_START_DEF = 16'd2000;
  localparam logic [15:0] RAMP_DEC_DEF   = 16'd50;

endpackage

// File: rtl/step_period_gen.sv
// -----------------------------------------------------------------------------
// step_period_gen
// Loadable phase down-counter for the move controller. Latches the effective
// step period P = max(period_i, 2*PULSE_LOW) on accept_i and produces tick_o on
// the last cycle of the current nStep low or high phase.
// Optional: `STEP_RAMP_EN adds a trapezoidal period profile (accelerate from
// max(RAMP_START, P) down to P, decelerate symmetrically near the end).
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   accept_i         new move accepted (latch period, restart profile)
//   period_i         requested Clk cycles per step
//   load_low_i       entering the low phase of a step
//   load_high_i      entering the high phase of a step
//   steps_rem_i      steps left before this step is counted (ramp build only)
//   tick_o           current phase ends this cycle
// -----------------------------------------------------------------------------
module step_period_gen
  import step_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned PULSE_LOW = PULSE_LOW_DEF
`ifdef STEP_RAMP_EN
  ,
  parameter int unsigned      CNT_W      = 16,
  parameter logic [DIV_W-1:0] RAMP_START = DIV_W'(RAMP_START_DEF),
  parameter logic [DIV_W-1:0] RAMP_DEC   = DIV_W'(RAMP_DEC_DEF)
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             accept_i,
  input  logic [DIV_W-1:0] period_i,
  input  logic             load_low_i,
  input  logic             load_high_i,
`ifdef STEP_RAMP_EN
  input  logic [CNT_W-1:0] steps_rem_i,
`endif
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] MIN_P     = DIV_W'(2 * PULSE_LOW);
  localparam logic [DIV_W-1:0] LOW_LD    = DIV_W'(PULSE_LOW - 1);
  localparam logic [DIV_W-1:0] HIGH_ADJ  = DIV_W'(PULSE_LOW + 1);

  logic [DIV_W-1:0] p_eff;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;

  assign p_eff  = (period_i > MIN_P) ? period_i : MIN_P;
  assign tick_o = (cnt_q == '0);

  // Counter holds "cycles remaining minus one"; high phase spans per - PULSE_LOW.
  always_comb begin
    cnt_d = cnt_q;
    if (load_low_i)
      cnt_d = LOW_LD;
    else if (load_high_i)
      cnt_d = per_q - HIGH_ADJ;
    else if (cnt_q != '0)
      cnt_d = cnt_q - DIV_W'(1);
  end

`ifdef STEP_RAMP_EN
  logic [DIV_W-1:0] floor_q, floor_d;
  logic [CNT_W-1:0] rc_q, rc_d;
  logic             first_q, first_d;

  // per_q is the period of the step whose low phase is running; it is updated
  // on low-phase entry so the following high phase uses the new value.
  always_comb begin
    per_d   = per_q;
    floor_d = floor_q;
    rc_d    = rc_q;
    first_d = first_q;
    if (accept_i) begin
      floor_d = p_eff;
      per_d   = (RAMP_START > p_eff) ? RAMP_START : p_eff;
      rc_d    = '0;
      first_d = 1'b1;
    end else if (load_low_i) begin
      if (first_q) begin
        first_d = 1'b0;
      end else if (steps_rem_i <= rc_q) begin
        per_d = per_q + RAMP_DEC;
      end else if (per_q > floor_q) begin
        per_d = ((per_q - floor_q) > RAMP_DEC) ? (per_q - RAMP_DEC) : floor_q;
        rc_d  = rc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      floor_q <= MIN_P;
      rc_q    <= '0;
      first_q <= 1'b0;
    end else begin
      floor_q <= floor_d;
      rc_q    <= rc_d;
      first_q <= first_d;
    end
  end
`else
  always_comb begin
    per_d = accept_i ? p_eff : per_q;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      per_q <= MIN_P;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/step_move_sequencer.sv
// -----------------------------------------------------------------------------
// step_move_sequencer
// Move-level controller in front of the stepper phase sequencer. Accepts a move
// (steps, direction, full/half, period) over CmdValid/CmdReady, emits exactly
// that many nStep low pulses at the programmed rate, then pulses Done.
// Optional: `STEP_RAMP_EN enables a trapezoidal period profile.
// Ports:
//   Clk, nReset                 clock, async active-low reset
//   Enable                      motor power request (loss while busy aborts)
//   CmdValid/CmdReady           command handshake
//   CmdSteps/CmdDir/CmdHalf     move length, 1 = clockwise, 1 = half step
//   CmdPeriod                   Clk cycles per step (clamped to 2*PULSE_LOW)
//   Abort                       stop current move
//   nStep/MotDir/OnOff/Hold/FullnHalf   sequencer controls
//   Busy, Done, Aborted, StepsLeft      move status
// -----------------------------------------------------------------------------
module step_move_sequencer
  import step_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned PULSE_LOW = PULSE_LOW_DEF
`ifdef STEP_RAMP_EN
  ,
  parameter logic [DIV_W-1:0] RAMP_START = DIV_W'(RAMP_START_DEF),
  parameter logic [DIV_W-1:0] RAMP_DEC   = DIV_W'(RAMP_DEC_DEF)
`endif
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Enable,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [CNT_W-1:0] CmdSteps,
  input  logic             CmdDir,
  input  logic             CmdHalf,
  input  logic [DIV_W-1:0] CmdPeriod,
  input  logic             Abort,
  output logic             nStep,
  output logic             MotDir,
  output logic             OnOff,
  output logic             Hold,
  output logic             FullnHalf,
  output logic             Busy,
  output logic             Done,
  output logic             Aborted,
  output logic [CNT_W-1:0] StepsLeft
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d;
  logic             full_q, full_d;
  logic             pend_q, pend_d;
  logic             aborted_q, aborted_d;
  logic             nstep_q, onoff_q;
  logic             accept, load_low, load_high, tick, stop;

  assign stop = Abort | ~Enable;

  // Gated by nReset so the handshake is closed while reset is held.
  assign CmdReady  = nReset & (state_q == S_IDLE) & Enable;
  assign Busy      = (state_q == S_SETUP) | (state_q == S_LOW) | (state_q == S_HIGH);
  assign Hold      = ~Busy;
  assign Done      = (state_q == S_DONE);
  assign Aborted   = aborted_q;
  assign nStep     = nstep_q;
  assign MotDir    = dir_q;
  assign FullnHalf = full_q;
  assign OnOff     = onoff_q;
  assign StepsLeft = steps_q;

  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    dir_d     = dir_q;
    full_d    = full_q;
    pend_d    = pend_q;
    aborted_d = 1'b0;
    accept    = 1'b0;
    load_low  = 1'b0;
    load_high = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CmdValid && CmdReady) begin
          accept  = 1'b1;
          steps_d = CmdSteps;
          dir_d   = CmdDir;
          full_d  = ~CmdHalf;
          pend_d  = 1'b0;
          state_d = (CmdSteps == '0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (stop) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d  = S_LOW;
          load_low = 1'b1;
          if (steps_q != '0) steps_d = steps_q - CNT_W'(1);
        end
      end
      // An abort seen during the low phase lets the pulse finish (the step has
      // already been counted) and then ends the move without a high phase.
      S_LOW: begin
        if (tick) begin
          if (pend_q || stop) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
          end else begin
            state_d   = S_HIGH;
            load_high = 1'b1;
          end
        end else if (stop) begin
          pend_d = 1'b1;
        end
      end
      S_HIGH: begin
        if (stop || pend_q) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (tick) begin
          if (steps_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_LOW;
            load_low = 1'b1;
            steps_d  = steps_q - CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      steps_q   <= '0;
      dir_q     <= 1'b1;
      full_q    <= 1'b1;
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
      nstep_q   <= 1'b1;
      onoff_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      dir_q     <= dir_d;
      full_q    <= full_d;
      pend_q    <= pend_d;
      aborted_q <= aborted_d;
      nstep_q   <= (state_d != S_LOW);
      onoff_q   <= Enable;
    end
  end

  step_period_gen #(
    .DIV_W     (DIV_W),
    .PULSE_LOW (PULSE_LOW)
`ifdef STEP_RAMP_EN
    ,
    .CNT_W     (CNT_W),
    .RAMP_START(RAMP_START),
    .RAMP_DEC  (RAMP_DEC)
`endif
  ) u_period (
    .clk_i      (Clk),
    .rst_n_i    (nReset),
    .accept_i   (accept),
    .period_i   (CmdPeriod),
    .load_low_i (load_low),
    .load_high_i(load_high),
`ifdef STEP_RAMP_EN
    .steps_rem_i(steps_q),
`endif
    .tick_o     (tick)
  );

endmodule
